// File: rtl/uart_pkg.sv
// Shared UART definitions (TX and RX): parity modes, FSM state encoding and
// baud divisor helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned DIV_MIN = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6,
    ST_MAB    = 3'd7
  } tx_state_e;

  // Clocks per bit for a fixed baud rate, truncated and floored at DIV_MIN.
  function automatic int unsigned default_div(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    int unsigned q;
    q = clk_freq / baud_rate;
    return (q < DIV_MIN) ? DIV_MIN : q;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable D-cycle bit-period counter; bit_end_c marks the last cycle of each
// bit and bit_pre_end_c the cycle before it.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             bit_end_c,
  output logic             bit_pre_end_c
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin : p_cnt
    if (!rst_n) begin
      div_q <= DIV_W'(DIV_MIN);
      cnt_q <= '0;
    end else if (load) begin
      div_q <= div;
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= bit_end_c ? '0 : cnt_q + DIV_W'(1);
    end
  end

  assign bit_end_c     = run && (cnt_q == div_q - DIV_W'(1));
  assign bit_pre_end_c = run && (cnt_q == div_q - DIV_W'(2));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready byte intake, runtime divisor/parity/stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input (line break + mark-after-break).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DIV_W     = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned DEF_DIV = default_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned IDX_W   = $clog2(DATA_W);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be within 5..9");
  end
  if (64'(DEF_DIV) >= (64'd1 << DIV_W)) begin : g_bad_def_div
    $error("uart_tx_frame: CLK_FREQ/BAUD_RATE does not fit in DIV_W bits");
  end

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic [DIV_W-1:0]  eff_div_c;
  logic              hs_c;
  logic              cnt_load_c;
  logic              bit_end_c;
  logic              bit_pre_end_c;
  logic              line_d;
  logic              done_d;

  assign hs_c = tx_valid && tx_ready;

  // Effective clocks per bit: 0 selects the elaborated default, tiny values clamp up.
  always_comb begin : p_div
    if (baud_div == '0) begin
      eff_div_c = DIV_W'(DEF_DIV);
    end else if (baud_div < DIV_W'(DIV_MIN)) begin
      eff_div_c = DIV_W'(DIV_MIN);
    end else begin
      eff_div_c = baud_div;
    end
  end

  uart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud_cnt (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .load          (cnt_load_c),
    .div           (eff_div_c),
    .run           (state_q != ST_IDLE),
    .bit_end_c     (bit_end_c),
    .bit_pre_end_c (bit_pre_end_c)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin : p_state
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      uart_tx   <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      if (hs_c) begin
        par_en_q  <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
        par_bit_q <= (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
        stop2_q   <= stop2;
      end
      uart_tx  <= line_d;
      tx_ready <= (state_d == ST_IDLE);
      tx_busy  <= (state_d != ST_IDLE);
      tx_done  <= done_d;
    end
  end

  // Next state; data shifts right so the bit on the line is always data_q[0].
  always_comb begin : p_next
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    cnt_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          state_d    = ST_START;
          data_d     = tx_data;
          cnt_load_c = 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        else if (tx_break) begin
          state_d    = ST_BREAK;
          cnt_load_c = 1'b1;
        end
`endif
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          data_d = data_q >> 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (bit_end_c) state_d = stop2_q ? ST_STOP2 : ST_IDLE;
      end
      ST_STOP2: begin
        if (bit_end_c) state_d = ST_IDLE;
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!tx_break) begin
          state_d    = ST_MAB;
          idx_d      = '0;
          cnt_load_c = 1'b1;
        end
      end
      // Mark-after-break spans two bit periods.
      ST_MAB: begin
        if (bit_end_c) begin
          if (idx_q != '0) state_d = ST_IDLE;
          else             idx_d   = IDX_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and done strobe for the coming cycle.
  always_comb begin : p_out
    line_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      ST_START, ST_BREAK: line_d = 1'b0;
      ST_DATA:            line_d = data_d[0];
      ST_PARITY:          line_d = par_bit_q;
      default:            line_d = 1'b1;
    endcase
    if (((state_q == ST_STOP1) && !stop2_q) || (state_q == ST_STOP2)) begin
      done_d = bit_pre_end_c;
    end
  end

endmodule
